// File: rtl/simd_iter_pkg.sv
// Shared opcode/function constants, FSM state type and operand-validity decode
// for the SIMD iterator address generator.
package simd_iter_pkg;

    localparam logic [3:0] OP_ITER   = 4'b0110;
    localparam logic [3:0] FN_IMM_LO = 4'b1000;
    localparam logic [3:0] FN_IMM_HI = 4'b1001;
    localparam logic [3:0] FN_IMM_SE = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        RESTORE
    } iter_state_e;

    typedef struct packed {
        logic src1;
        logic src2;
        logic dest;
    } operand_valid_t;

    function automatic operand_valid_t decodeOperands(input logic [3:0] opcode,
                                                      input logic [3:0] fn);
        operand_valid_t v;
        v = '0;
        case (opcode)
            4'b0000: begin
                if (fn != 4'b1111) begin
                    v = '{src1: 1'b1, src2: 1'b1, dest: 1'b1};
                end
            end
            4'b0010, 4'b0011, 4'b0111: v = '{src1: 1'b1, src2: 1'b1, dest: 1'b1};
            4'b0001: begin
                v.src1 = 1'b1;
                v.dest = 1'b1;
                v.src2 = (fn >= 4'b0001) && (fn <= 4'b0011);
            end
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/iterator_table.sv
// One namespace of iterator state: base, stride and shadow base per entry, with a
// config write port, three read ports, per-entry post-increment and bulk restore.
module iterator_table #(
    parameter int DEPTH    = 8,
    parameter int IDX_BITS = 5,
    parameter int WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_wrEn,
    input  logic                          i_wrStride,
    input  logic [IDX_BITS-1:0]           i_wrIdx,
    input  logic [WIDTH-1:0]              i_wrData,
    input  logic [2:0][IDX_BITS-1:0]      i_rdIdx,
    output logic [2:0][WIDTH-1:0]         o_rdData,
    input  logic [DEPTH-1:0]              i_incMask,
    input  logic                          i_restore
);

    logic [WIDTH-1:0] r_base   [DEPTH];
    logic [WIDTH-1:0] r_stride [DEPTH];
    logic [WIDTH-1:0] r_shadow [DEPTH];

    // Restore beats config writes, which beat post-increment on the same entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_base[i]   <= '0;
                r_stride[i] <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_restore) begin
                    r_base[i] <= r_shadow[i];
                end else if (i_wrEn && !i_wrStride && (i_wrIdx == IDX_BITS'(i))) begin
                    r_base[i]   <= i_wrData;
                    r_shadow[i] <= i_wrData;
                end else if (i_incMask[i]) begin
                    r_base[i] <= r_base[i] + r_stride[i];
                end
                if (!i_restore && i_wrEn && i_wrStride && (i_wrIdx == IDX_BITS'(i))) begin
                    r_stride[i] <= i_wrData;
                end
            end
        end
    end

    always_comb begin
        o_rdData = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_rdIdx[k] == IDX_BITS'(i)) begin
                    o_rdData[k] = r_base[i];
                end
            end
        end
    end

endmodule

// File: rtl/iterator_address_gen_v2.sv
// SIMD iterator address generator: decodes iterator config / compute instructions
// and emits registered operand base addresses, with loop post-increment and restore.
module iterator_address_gen_v2
    import simd_iter_pkg::*;
#(
    parameter int NUM_NS            = 6,
    parameter int NS_ID_BITS        = 3,
    parameter int NS_INDEX_ID_BITS  = 5,
    parameter int ITER_DEPTH        = 8,
    parameter int OPCODE_BITS       = 4,
    parameter int FUNCTION_BITS     = 4,
    parameter int BASE_STRIDE_WIDTH = 32,
    parameter int IMMEDIATE_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic [OPCODE_BITS-1:0]       opcode,
    input  logic [FUNCTION_BITS-1:0]     fn,
    input  logic [NS_ID_BITS-1:0]        dest_ns_id,
    input  logic [NS_ID_BITS-1:0]        src1_ns_id,
    input  logic [NS_ID_BITS-1:0]        src2_ns_id,
    input  logic [NS_INDEX_ID_BITS-1:0]  dest_ns_index_id,
    input  logic [NS_INDEX_ID_BITS-1:0]  src1_ns_index_id,
    input  logic [NS_INDEX_ID_BITS-1:0]  src2_ns_index_id,
    input  logic                         loop_start,
    input  logic                         loop_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_src1_valid,
    output logic                         out_src2_valid,
    output logic                         out_dest_valid,
    output logic [NS_ID_BITS-1:0]        out_src1_ns,
    output logic [NS_ID_BITS-1:0]        out_src2_ns,
    output logic [NS_ID_BITS-1:0]        out_dest_ns,
    output logic [BASE_STRIDE_WIDTH-1:0] out_src1_addr,
    output logic [BASE_STRIDE_WIDTH-1:0] out_src2_addr,
    output logic [BASE_STRIDE_WIDTH-1:0] out_dest_addr,
    output logic [IMMEDIATE_WIDTH-1:0]   immediate_out,
    output logic                         loop_active,
    output logic                         cfg_err
);

    localparam int HALF  = BASE_STRIDE_WIDTH / 2;
    localparam int CAT_W = 2 * (NS_ID_BITS + NS_INDEX_ID_BITS);

    iter_state_e r_state, w_nextState;

    logic                                        w_accept, w_isIter, w_isCfg, w_cfgInRange;
    logic                                        w_restore, w_opErr;
    logic [CAT_W-1:0]                            w_immCat;
    logic [15:0]                                 w_imm16, r_heldLow;
    logic [BASE_STRIDE_WIDTH-1:0]                w_cfgData;
    operand_valid_t                              w_decode;
    logic [2:0][NS_ID_BITS-1:0]                  w_opNs;
    logic [2:0][NS_INDEX_ID_BITS-1:0]            w_opIdx;
    logic [2:0]                                  w_opInRange, w_opValid;
    logic [2:0][BASE_STRIDE_WIDTH-1:0]           w_opAddr;
    logic [NUM_NS-1:0][2:0][BASE_STRIDE_WIDTH-1:0] w_rdBase;
    logic [NUM_NS-1:0][ITER_DEPTH-1:0]           w_incMask;
    logic [NUM_NS-1:0]                           w_cfgWrEn;

    assign inst_ready  = reset && (r_state != RESTORE) && (!out_valid || out_ready);
    assign w_accept    = inst_valid && inst_ready;
    assign loop_active = (r_state == LOOP);
    assign w_restore   = (r_state == RESTORE);

    assign w_isIter = (4'(opcode) == OP_ITER);
    assign w_isCfg  = w_isIter && !fn[3];
    assign w_immCat = {src1_ns_id, src1_ns_index_id, src2_ns_id, src2_ns_index_id};
    assign w_imm16  = 16'(w_immCat);

    assign w_cfgInRange = (int'(dest_ns_id) < NUM_NS) && (int'(dest_ns_index_id) < ITER_DEPTH);

    // Operand slot order throughout: 0 = src1, 1 = src2, 2 = dest.
    assign w_opNs  = {dest_ns_id, src2_ns_id, src1_ns_id};
    assign w_opIdx = {dest_ns_index_id, src2_ns_index_id, src1_ns_index_id};
    assign w_decode = decodeOperands(4'(opcode), 4'(fn));

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_opInRange[k] = (int'(w_opNs[k]) < NUM_NS) && (int'(w_opIdx[k]) < ITER_DEPTH);
        end
        w_opValid[0] = w_decode.src1 && w_opInRange[0];
        w_opValid[1] = w_decode.src2 && w_opInRange[1];
        w_opValid[2] = w_decode.dest && w_opInRange[2];
        w_opErr = (w_decode.src1 && !w_opInRange[0]) ||
                  (w_decode.src2 && !w_opInRange[1]) ||
                  (w_decode.dest && !w_opInRange[2]);
    end

    always_comb begin
        case (fn[1:0])
            2'b00:   w_cfgData = BASE_STRIDE_WIDTH'($signed(w_imm16));
            2'b11:   w_cfgData = BASE_STRIDE_WIDTH'(w_imm16);
            default: w_cfgData = {HALF'(w_imm16), HALF'(r_heldLow)};
        endcase
    end

    always_comb begin
        w_opAddr  = '0;
        w_incMask = '0;
        w_cfgWrEn = '0;
        for (int n = 0; n < NUM_NS; n++) begin
            w_cfgWrEn[n] = w_accept && w_isCfg && w_cfgInRange && (int'(dest_ns_id) == n);
            for (int k = 0; k < 3; k++) begin
                if (w_opValid[k] && (int'(w_opNs[k]) == n)) begin
                    w_opAddr[k] = w_rdBase[n][k];
                    // OR-ing per entry makes a repeated reference increment only once.
                    for (int i = 0; i < ITER_DEPTH; i++) begin
                        if (w_accept && (r_state == LOOP) && (int'(w_opIdx[k]) == i)) begin
                            w_incMask[n][i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_NS; n++) begin : g_ns
        iterator_table #(
            .DEPTH    (ITER_DEPTH),
            .IDX_BITS (NS_INDEX_ID_BITS),
            .WIDTH    (BASE_STRIDE_WIDTH)
        ) u_table (
            .clk        (clk),
            .reset      (reset),
            .i_wrEn     (w_cfgWrEn[n]),
            .i_wrStride (fn[2]),
            .i_wrIdx    (dest_ns_index_id),
            .i_wrData   (w_cfgData),
            .i_rdIdx    (w_opIdx),
            .o_rdData   (w_rdBase[n]),
            .i_incMask  (w_incMask[n]),
            .i_restore  (w_restore)
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (loop_start && !loop_done) w_nextState = LOOP;
            LOOP:    if (loop_done) w_nextState = RESTORE;
            RESTORE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_src1_valid <= 1'b0;
            out_src2_valid <= 1'b0;
            out_dest_valid <= 1'b0;
            out_src1_ns    <= '0;
            out_src2_ns    <= '0;
            out_dest_ns    <= '0;
            out_src1_addr  <= '0;
            out_src2_addr  <= '0;
            out_dest_addr  <= '0;
        end else if (w_accept && (|w_opValid)) begin
            out_valid      <= 1'b1;
            out_src1_valid <= w_opValid[0];
            out_src2_valid <= w_opValid[1];
            out_dest_valid <= w_opValid[2];
            out_src1_ns    <= src1_ns_id;
            out_src2_ns    <= src2_ns_id;
            out_dest_ns    <= dest_ns_id;
            out_src1_addr  <= w_opAddr[0];
            out_src2_addr  <= w_opAddr[1];
            out_dest_addr  <= w_opAddr[2];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_heldLow     <= '0;
            immediate_out <= '0;
            cfg_err       <= 1'b0;
        end else if (w_accept) begin
            if (w_isCfg) begin
                r_heldLow <= w_imm16;
            end
            if (w_isIter) begin
                case (4'(fn))
                    FN_IMM_LO: immediate_out[15:0]  <= w_imm16;
                    FN_IMM_HI: immediate_out[31:16] <= w_imm16;
                    FN_IMM_SE: immediate_out        <= IMMEDIATE_WIDTH'($signed(w_imm16));
                    default:   ;
                endcase
            end
            if ((w_isCfg && !w_cfgInRange) || w_opErr) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule
